// File: rtl/kypd_scanner_if.sv
// ---------------------------------------------------------------------------
// kypd_scanner_if
// Bundles the keypad matrix pins and the debounced key outputs of
// kypd_scanner so the scanner and its neighbours connect through one port.
//
// Signals:
//   col_n       column drive, active-low one-hot (scanner -> matrix)
//   row_n       raw row sense, pulled up, active-low (matrix -> scanner)
//   key         accepted key code
//   key_valid   high while an accepted key is held
//   key_press   one-cycle pulse when a key is accepted
//   key_release one-cycle pulse on release (only with KYPD_RELEASE_PULSE_EN)
//
// Modports:
//   master  the scanner side (drives columns and key outputs)
//   slave   the keypad/consumer side (drives rows, observes key outputs)
//
// Optional feature macro: KYPD_RELEASE_PULSE_EN
// ---------------------------------------------------------------------------
interface kypd_scanner_if;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       key_valid;
   logic       key_press;
`ifdef KYPD_RELEASE_PULSE_EN
   logic       key_release;

   modport master (output col_n, output key, output key_valid,
                   output key_press, output key_release, input row_n);
   modport slave  (input col_n, input key, input key_valid,
                   input key_press, input key_release, output row_n);
`else
   modport master (output col_n, output key, output key_valid,
                   output key_press, input row_n);
   modport slave  (input col_n, input key, input key_valid,
                   input key_press, output row_n);
`endif
endinterface

// File: rtl/kypd_scanner.sv
// ---------------------------------------------------------------------------
// kypd_scanner
// Scans the 4x4 Pmod keypad matrix one column at a time, classifies each
// full scan as no key / one key / several keys, debounces the result over
// DEBOUNCE_SCANS identical scans and reports the accepted key.
//
// Parameters:
//   SCAN_CYCLES     clocks each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical full scans needed to accept a new state (>= 1)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      kypd_scanner_if.master: col_n out, row_n in, key, key_valid,
//            key_press and (optionally) key_release out
//
// Optional feature macro: KYPD_RELEASE_PULSE_EN adds the key_release pulse
// on the held-key -> no-key acceptance.
// ---------------------------------------------------------------------------
module kypd_scanner #(
   parameter int SCAN_CYCLES    = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   kypd_scanner_if.master bus
);

   localparam int DW = $clog2(SCAN_CYCLES);
   localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_MAX  = MW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;
   typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_kind_t;

   // Key legend indexed by sample bit (column*4 + row, row 0 at the top).
   function automatic logic [3:0] code_of(input int idx);
      logic [3:0] c;
      case (idx)
         0:  c = 4'h1;  1: c = 4'h4;  2: c = 4'h7;  3: c = 4'h0;
         4:  c = 4'h2;  5: c = 4'h5;  6: c = 4'h8;  7: c = 4'hF;
         8:  c = 4'h3;  9: c = 4'h6; 10: c = 4'h9; 11: c = 4'hE;
         12: c = 4'hA; 13: c = 4'hB; 14: c = 4'hC; default: c = 4'hD;
      endcase
      return c;
   endfunction

   logic [3:0]    row_meta_q, row_meta_d, row_sync_q, row_sync_d;
   col_state_t    state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [11:0]   samp_q, samp_d;
   cls_kind_t     cand_kind_q, cand_kind_d;
   logic [3:0]    cand_code_q, cand_code_d;
   logic [MW-1:0] match_q, match_d;
   logic [3:0]    key_q, key_d;
   logic          key_valid_q, key_valid_d;
   logic          key_press_q, key_press_d;
   logic          key_release_q, key_release_d;

   logic [15:0]   all_bits;
   logic [1:0]    low_cnt;
   logic [3:0]    low_code;
   cls_kind_t     new_kind;
   logic [3:0]    new_code;
   logic          same_cand;
   logic [MW-1:0] match_next;

   // Classify the full scan as it stands in the final COL3 dwell cycle: the
   // three stored column nibbles plus the live synchronized rows for COL3.
   // Codes are forced to zero for NONE/MULTI so candidate compares stay simple.
   always_comb begin
      all_bits = {row_sync_q, samp_q};
      low_cnt  = 2'd0;
      low_code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (!all_bits[i]) begin
            low_cnt  = (low_cnt == 2'd0) ? 2'd1 : 2'd2;
            low_code = code_of(i);
         end
      end
      case (low_cnt)
         2'd0:    new_kind = CLS_NONE;
         2'd1:    new_kind = CLS_SINGLE;
         default: new_kind = CLS_MULTI;
      endcase
      new_code   = (new_kind == CLS_SINGLE) ? low_code : 4'h0;
      same_cand  = (new_kind == cand_kind_q) && (new_code == cand_code_q);
      match_next = !same_cand ? MW'(1) :
                   (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
   end

   // Next-state logic: dwell counting, column rotation, per-column sampling
   // and, at the end of COL3, the debounce/acceptance decision. A MULTI
   // candidate can saturate the counter but never changes the outputs.
   always_comb begin
      row_meta_d    = bus.row_n;
      row_sync_d    = row_meta_q;
      state_d       = state_q;
      dwell_d       = dwell_q;
      samp_d        = samp_q;
      cand_kind_d   = cand_kind_q;
      cand_code_d   = cand_code_q;
      match_d       = match_q;
      key_d         = key_q;
      key_valid_d   = key_valid_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;

      if (dwell_q != DWELL_LAST) begin
         dwell_d = dwell_q + DW'(1);
      end else begin
         dwell_d = '0;
         case (state_q)
            COL0: begin samp_d[3:0]  = row_sync_q; state_d = COL1; end
            COL1: begin samp_d[7:4]  = row_sync_q; state_d = COL2; end
            COL2: begin samp_d[11:8] = row_sync_q; state_d = COL3; end
            default: begin
               state_d     = COL0;
               cand_kind_d = new_kind;
               cand_code_d = new_code;
               match_d     = match_next;
               if (match_next == MATCH_MAX) begin
                  if (new_kind == CLS_NONE && key_valid_q) begin
                     key_valid_d   = 1'b0;
                     key_release_d = 1'b1;
                  end else if (new_kind == CLS_SINGLE &&
                               (!key_valid_q || key_q != new_code)) begin
                     key_d       = new_code;
                     key_valid_d = 1'b1;
                     key_press_d = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // State register. Reset discards all scan and debounce history and puts
   // the synchronizer in the idle (all rows released) state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_meta_q    <= 4'hF;
         row_sync_q    <= 4'hF;
         state_q       <= COL0;
         dwell_q       <= '0;
         samp_q        <= '1;
         cand_kind_q   <= CLS_NONE;
         cand_code_q   <= 4'h0;
         match_q       <= '0;
         key_q         <= 4'h0;
         key_valid_q   <= 1'b0;
         key_press_q   <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         row_meta_q    <= row_meta_d;
         row_sync_q    <= row_sync_d;
         state_q       <= state_d;
         dwell_q       <= dwell_d;
         samp_q        <= samp_d;
         cand_kind_q   <= cand_kind_d;
         cand_code_q   <= cand_code_d;
         match_q       <= match_d;
         key_q         <= key_d;
         key_valid_q   <= key_valid_d;
         key_press_q   <= key_press_d;
         key_release_q <= key_release_d;
      end
   end

   assign bus.col_n     = ~(4'b0001 << state_q);
   assign bus.key       = key_q;
   assign bus.key_valid = key_valid_q;
   assign bus.key_press = key_press_q;
`ifdef KYPD_RELEASE_PULSE_EN
   assign bus.key_release = key_release_q;
`else
   logic unused_release;
   assign unused_release = key_release_q;
`endif

endmodule

// File: tb/tb_kypd_scanner.sv
// ---------------------------------------------------------------------------
// tb_kypd_scanner
// Directed bench for kypd_scanner with SCAN_CYCLES=8, DEBOUNCE_SCANS=2.
// A combinational matrix model turns the set of pressed keys and the live
// column drive into row_n. Scenarios: reset, bounce, release, roll-over,
// ghost (two keys), and reset during operation.
// ---------------------------------------------------------------------------
module tb_kypd_scanner;

   localparam int SC   = 8;
   localparam int DB   = 2;
   localparam int SCAN = 4 * SC;

   // Pressed-key bit positions: column*4 + row
   localparam int K1 = 0;
   localparam int K2 = 4;
   localparam int K3 = 8;
   localparam int K5 = 5;
   localparam int K9 = 10;
   localparam int KA = 12;
   localparam int KD = 15;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pressed;

   int errors = 0;
   int checks = 0;

   int         press_cnt;
   int         release_cnt;
   int         valid_low_cnt;
   logic [3:0] press_key;

   kypd_scanner_if bus ();

   kypd_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Matrix model: a pressed key pulls its row low while its column is driven.
   function automatic logic [3:0] row_model(input logic [3:0] col_n, input logic [15:0] keys);
      logic [3:0] r;
      r = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            if (!col_n[c] && keys[c*4+rr]) r[rr] = 1'b0;
      return r;
   endfunction

   assign bus.row_n = row_model(bus.col_n, pressed);

   // Pulse/level monitor, sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (bus.key_press === 1'b1) begin
         press_cnt = press_cnt + 1;
         press_key = bus.key;
      end
`ifdef KYPD_RELEASE_PULSE_EN
      if (bus.key_release === 1'b1) release_cnt = release_cnt + 1;
`endif
      if (bus.key_valid !== 1'b1) valid_low_cnt = valid_low_cnt + 1;
   end

   task automatic clear_counts();
      press_cnt     = 0;
      release_cnt   = 0;
      valid_low_cnt = 0;
      press_key     = 4'h0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic idle();
      pressed = 16'h0;
      tick(3 * SCAN);
   endtask

   // Lands on the negedge right after the COL3 -> COL0 transition.
   task automatic align_scan();
      logic [3:0] prev;
      prev = bus.col_n;
      checks++;
      for (int i = 0; i < 3 * SCAN; i++) begin
         @(negedge clk);
         if (prev == 4'b0111 && bus.col_n == 4'b1110) return;
         prev = bus.col_n;
      end
      errors++;
      $display("[TB] FAIL align_scan: no COL3->COL0 transition seen, col_n=%b", bus.col_n);
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      reset_n = 1'b0;
      pressed = 16'h0;
      pressed[K5] = 1'b1;
      tick(3);
      checks++;
      if (bus.col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col_n: got %b expected 1110", bus.col_n); end
      checks++;
      if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid: got %b expected 0", bus.key_valid); end
      checks++;
      if (bus.key_press !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_press: got %b expected 0", bus.key_press); end
      checks++;
      if (bus.key !== 4'h0) begin errors++; $display("[TB] FAIL reset_key: got %h expected 0", bus.key); end
`ifdef KYPD_RELEASE_PULSE_EN
      checks++;
      if (bus.key_release !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_release: got %b expected 0", bus.key_release); end
`endif
      reset_n = 1'b1;
      clear_counts();
      for (int i = 0; i < SCAN; i++) begin
         exp_col = ~(4'b0001 << (i / SC));
         checks++;
         if (bus.col_n !== exp_col) begin
            errors++;
            $display("[TB] FAIL col_rotate[%0d]: got %b expected %b", i, bus.col_n, exp_col);
         end
         tick(1);
      end
      tick(99 - SCAN);
      checks++;
      if (press_cnt != 1) begin errors++; $display("[TB] FAIL first_press_count: got %0d expected 1", press_cnt); end
      checks++;
      if (press_key !== 4'h5) begin errors++; $display("[TB] FAIL first_press_key: got %h expected 5", press_key); end
      checks++;
      if (bus.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL first_press_valid: got %b expected 1", bus.key_valid); end
   endtask

   task automatic test_bounce();
      idle();
      align_scan();
      clear_counts();
      for (int s = 0; s < 6; s++) begin
         pressed = 16'h0;
         if (s % 2 == 0) pressed[KA] = 1'b1;
         tick(SCAN);
      end
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL bounce_no_press: got %0d expected 0", press_cnt); end
      checks++;
      if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL bounce_valid: got %b expected 0", bus.key_valid); end
      pressed = 16'h0;
      pressed[KA] = 1'b1;
      tick(SCAN);
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL bounce_hold1: got %0d expected 0", press_cnt); end
      tick(SCAN);
      checks++;
      if (press_cnt != 1) begin errors++; $display("[TB] FAIL bounce_hold2_count: got %0d expected 1", press_cnt); end
      checks++;
      if (bus.key !== 4'hA) begin errors++; $display("[TB] FAIL bounce_key: got %h expected a", bus.key); end
      checks++;
      if (bus.key_press !== 1'b1) begin errors++; $display("[TB] FAIL bounce_pulse_high: got %b expected 1", bus.key_press); end
      tick(1);
      checks++;
      if (bus.key_press !== 1'b0) begin errors++; $display("[TB] FAIL bounce_pulse_width: got %b expected 0", bus.key_press); end
   endtask

   task automatic test_release();
      align_scan();
      clear_counts();
      pressed = 16'h0;
      tick(SCAN);
      checks++;
      if (bus.key_valid !== 1'b1) begin errors++; $display("[TB] FAIL release_early_valid: got %b expected 1", bus.key_valid); end
      tick(SCAN);
      checks++;
      if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected 0", bus.key_valid); end
      checks++;
      if (bus.key !== 4'hA) begin errors++; $display("[TB] FAIL release_key_hold: got %h expected a", bus.key); end
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL release_no_press: got %0d expected 0", press_cnt); end
`ifdef KYPD_RELEASE_PULSE_EN
      checks++;
      if (bus.key_release !== 1'b1) begin errors++; $display("[TB] FAIL release_pulse_high: got %b expected 1", bus.key_release); end
      checks++;
      if (release_cnt != 1) begin errors++; $display("[TB] FAIL release_count: got %0d expected 1", release_cnt); end
      tick(1);
      checks++;
      if (bus.key_release !== 1'b0) begin errors++; $display("[TB] FAIL release_pulse_width: got %b expected 0", bus.key_release); end
`endif
   endtask

   task automatic test_rollover();
      idle();
      align_scan();
      clear_counts();
      pressed = 16'h0;
      pressed[K1] = 1'b1;
      tick(2 * SCAN);
      checks++;
      if (press_cnt != 1 || bus.key !== 4'h1) begin
         errors++;
         $display("[TB] FAIL roll_first: got count=%0d key=%h expected count=1 key=1", press_cnt, bus.key);
      end
      clear_counts();
      pressed = 16'h0;
      pressed[KD] = 1'b1;
      tick(SCAN);
      checks++;
      if (press_cnt != 0 || bus.key !== 4'h1) begin
         errors++;
         $display("[TB] FAIL roll_wait: got count=%0d key=%h expected count=0 key=1", press_cnt, bus.key);
      end
      tick(SCAN);
      checks++;
      if (press_cnt != 1) begin errors++; $display("[TB] FAIL roll_press_count: got %0d expected 1", press_cnt); end
      checks++;
      if (bus.key !== 4'hD) begin errors++; $display("[TB] FAIL roll_key: got %h expected d", bus.key); end
      checks++;
      if (valid_low_cnt != 0) begin errors++; $display("[TB] FAIL roll_valid_held: got %0d low cycles expected 0", valid_low_cnt); end
      checks++;
      if (release_cnt != 0) begin errors++; $display("[TB] FAIL roll_no_release: got %0d expected 0", release_cnt); end
   endtask

   task automatic test_ghost();
      idle();
      align_scan();
      clear_counts();
      pressed = 16'h0;
      pressed[K2] = 1'b1;
      pressed[K3] = 1'b1;
      tick(3 * SCAN);
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL ghost_no_press: got %0d expected 0", press_cnt); end
      checks++;
      if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ghost_valid: got %b expected 0", bus.key_valid); end
      checks++;
      if (release_cnt != 0) begin errors++; $display("[TB] FAIL ghost_no_release: got %0d expected 0", release_cnt); end
      pressed[K3] = 1'b0;
      tick(SCAN);
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL ghost_single_wait: got %0d expected 0", press_cnt); end
      tick(SCAN);
      checks++;
      if (press_cnt != 1 || bus.key !== 4'h2 || bus.key_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ghost_single_accept: got count=%0d key=%h valid=%b expected count=1 key=2 valid=1",
                  press_cnt, bus.key, bus.key_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      idle();
      align_scan();
      clear_counts();
      pressed = 16'h0;
      pressed[K9] = 1'b1;
      tick(2 * SCAN);
      checks++;
      if (press_cnt != 1 || bus.key !== 4'h9) begin
         errors++;
         $display("[TB] FAIL mid_pre_accept: got count=%0d key=%h expected count=1 key=9", press_cnt, bus.key);
      end
      seen = 1'b0;
      for (int i = 0; i < 2 * SCAN && !seen; i++) begin
         @(negedge clk);
         if (bus.col_n == 4'b1011) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL mid_find_col2: got col_n=%b expected 1011", bus.col_n); end
      tick(3);
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.key_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", bus.key_valid); end
      checks++;
      if (bus.col_n !== 4'b1110) begin errors++; $display("[TB] FAIL mid_reset_col_n: got %b expected 1110", bus.col_n); end
      tick(2);
      reset_n = 1'b1;
      clear_counts();
      tick(2 * SCAN - 1);
      checks++;
      if (press_cnt != 0) begin errors++; $display("[TB] FAIL mid_requalify_early: got %0d expected 0", press_cnt); end
      tick(1);
      checks++;
      if (press_cnt != 1) begin errors++; $display("[TB] FAIL mid_requalify_count: got %0d expected 1", press_cnt); end
      checks++;
      if (bus.key !== 4'h9 || bus.key_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_requalify_key: got key=%h valid=%b expected key=9 valid=1", bus.key, bus.key_valid);
      end
   endtask

   initial begin
      pressed = 16'h0;
      reset_n = 1'b0;
      clear_counts();
      test_reset();
      test_bounce();
      test_release();
      test_rollover();
      test_ghost();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
